// File: rtl/adder_tree_pkg.sv
// Shared constants for the pipelined 8-operand adder tree.
// Output width grows by one bit per tree level: log2 of the operand count.
package adder_tree_pkg;

  localparam int N_OPERANDS   = 8;
  localparam int TREE_LEVELS  = 3;
  localparam int DEFAULT_IN_W = 8;

  function automatic int out_width(input int in_w);
    return in_w + $clog2(N_OPERANDS);
  endfunction

endpackage

// File: rtl/adder_tree_add2.sv
// One tree node: zero-extends two W-bit operands and registers their W+1-bit sum.
// Every tree level is built from this node.
module adder_tree_add2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  // Node register: the extra top bit keeps the carry, so the sum never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= {(W+1){1'b0}};
    end else begin
      sum <= {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Three-level registered binary adder tree (4 -> 2 -> 1 nodes).
// The inputs feed level 1 directly, and y is the root node's register.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = out_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic [IN_W-1:0]  c,
  input  logic [IN_W-1:0]  d,
  input  logic [IN_W-1:0]  e,
  input  logic [IN_W-1:0]  f,
  input  logic [IN_W-1:0]  g,
  input  logic [IN_W-1:0]  h,
  output logic [OUT_W-1:0] y
);

  logic [IN_W:0]   sum_ab_r;
  logic [IN_W:0]   sum_cd_r;
  logic [IN_W:0]   sum_ef_r;
  logic [IN_W:0]   sum_gh_r;
  logic [IN_W+1:0] sum_abcd_r;
  logic [IN_W+1:0] sum_efgh_r;
  logic [IN_W+2:0] sum_root_r;

  adder_tree_add2 #(.W(IN_W)) u_l1_ab (
    .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum_ab_r)
  );

  adder_tree_add2 #(.W(IN_W)) u_l1_cd (
    .clk(clk), .rst(rst), .a(c), .b(d), .sum(sum_cd_r)
  );

  adder_tree_add2 #(.W(IN_W)) u_l1_ef (
    .clk(clk), .rst(rst), .a(e), .b(f), .sum(sum_ef_r)
  );

  adder_tree_add2 #(.W(IN_W)) u_l1_gh (
    .clk(clk), .rst(rst), .a(g), .b(h), .sum(sum_gh_r)
  );

  adder_tree_add2 #(.W(IN_W+1)) u_l2_abcd (
    .clk(clk), .rst(rst), .a(sum_ab_r), .b(sum_cd_r), .sum(sum_abcd_r)
  );

  adder_tree_add2 #(.W(IN_W+1)) u_l2_efgh (
    .clk(clk), .rst(rst), .a(sum_ef_r), .b(sum_gh_r), .sum(sum_efgh_r)
  );

  // The root node register is the output register itself; nothing sits after it
  adder_tree_add2 #(.W(IN_W+2)) u_l3_root (
    .clk(clk), .rst(rst), .a(sum_abcd_r), .b(sum_efgh_r), .sum(sum_root_r)
  );

  assign y = OUT_W'(sum_root_r);

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: a reference model queues the expected y for every
// edge, and a monitor compares on the falling edge. Runs directed cases, then random vectors.
module tb_adder_tree_pipe;

  logic        clk;
  logic        rst;
  logic [7:0]  op [8];
  logic [10:0] y;

  int compared   = 0;
  int mismatched = 0;

  logic [10:0] sb [$];
  int          hist [$];

  adder_tree_pipe dut (
    .clk(clk), .rst(rst),
    .a(op[0]), .b(op[1]), .c(op[2]), .d(op[3]),
    .e(op[4]), .f(op[5]), .g(op[6]), .h(op[7]),
    .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: y after an edge is the plain sum sampled two edges earlier,
  // provided reset was high at all three of those edges; otherwise y is 0.
  always @(posedge clk) begin
    int s;
    s = 0;
    foreach (op[i]) s += int'(op[i]);
    if (!rst) begin
      hist.delete();
      sb.push_back(11'd0);
    end else begin
      hist.push_back(s);
      if (hist.size() >= 3) sb.push_back(11'(hist[hist.size()-3]));
      else                  sb.push_back(11'd0);
    end
  end

  // Monitor: compares y with the oldest expected value, away from the active edge
  always @(negedge clk) begin
    logic [10:0] exp_y;
    if (sb.size() > 0) begin
      exp_y = sb.pop_front();
      compared++;
      if (y !== exp_y) begin
        mismatched++;
        $display("FAIL pipe_y t=%0t: got %0d, expected %0d", $time, y, exp_y);
      end
    end
  end

  task automatic check_now(input string name, input logic [10:0] exp_y);
    compared++;
    if (y !== exp_y) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, y, exp_y);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    foreach (op[i]) op[i] = v;
  endtask

  task automatic set_seq();
    foreach (op[i]) op[i] = 8'(i + 1);
  endtask

  // Holds the current inputs for n edges; inputs change 1 time unit after an edge
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_seq();
    #2;
    check_now("reset_state", 11'd0);
    hold(2);

    // Release reset with 1..8 held: 0, 0, then 36, and stays 36 while held
    rst = 1'b1;
    hold(6);

    set_all(8'd255);
    hold(4);

    // Back-to-back stream: 0, 8, 36, 2040 on consecutive edges
    set_all(8'd0);   hold(1);
    set_all(8'd1);   hold(1);
    set_seq();       hold(1);
    set_all(8'd255); hold(1);
    set_seq();
    hold(4);

    // Asynchronous reset between edges while y = 36
    @(negedge clk);
    #2;
    check_now("pre_async_reset", 11'd36);
    rst = 1'b0;
    #1;
    check_now("async_reset_clear", 11'd0);
    hold(2);
    rst = 1'b1;
    hold(4);

    // Reset in the middle of a stream discards partial sums
    for (int k = 0; k < 3; k++) begin
      foreach (op[i]) op[i] = 8'($urandom_range(0, 255));
      hold(1);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    hold(1);
    rst = 1'b1;
    set_seq();
    hold(4);

    for (int k = 0; k < 1000; k++) begin
      foreach (op[i]) op[i] = 8'($urandom_range(0, 255));
      if (($urandom() % 16) == 0) set_all(8'd255);
      hold(1);
    end
    hold(4);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
